dog_slideshow_ctrl: RTL
=======================

# dog_slideshow_ctrl

Frame-synchronous controller that sequences the dog-image sprite display. It selects which dog asset image is active and generates the scaled, registered sprite ROM address from the VGA beam position. It also drives a 4-bit brightness level for the palette stage, so images cross-fade out and in. It sits between the VGA controller (DrawX/DrawY) and the per-image ROM/palette instances, and replaces free-running per-image address logic.

## Interface

- NUM_IMAGES, 10, number of dog images; valid index range 0..NUM_IMAGES-1 (2..16)
- HOLD_FRAMES, 120, frames each image is held at full brightness before auto-advance (≥1)
- IMG_W, 110, sprite width in ROM pixels
- IMG_H, 96, sprite height in ROM pixels
- ADDR_W, 14, ROM address width; IMG_W*IMG_H must fit
- vga_clk  input  1  pixel clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- DrawX  input  10  current beam column, 0..799
- DrawY  input  10  current beam row, 0..524
- pause  input  1  level; freezes the auto-advance hold counter
- next_req  input  1  button level; rising edge requests the next image
- prev_req  input  1  button level; rising edge requests the previous image
- img_sel  output  4  active image index; drives the ROM/palette mux
- rom_address  output  ADDR_W  scaled sprite ROM address, registered
- brightness  output  4  palette scale, 15 = full, 0 = black
- busy  output  1  high while a fade is in progress (state != SHOW)

## Operation

- frame_tick is an internal 1-cycle strobe. It is high on the first cycle where DrawY==480 and the registered previous DrawY!=480. All state, counter, img_sel and brightness changes occur only on frame_tick, except rom_address, request latching and reset.
- Request latch: rising edges of next_req and prev_req are detected against registered copies. An edge sets pending_dir to NEXT or PREV, and the latest edge overwrites an earlier one. If both edges occur in the same cycle, NEXT wins. Pending is held until it is consumed in SHOW.
- The FSM has three states: SHOW, FADE_OUT and FADE_IN.
  - SHOW, on tick:
    - If pending is set: target ← img_sel±1 (wrapping NUM_IMAGES-1↔0), clear pending, brightness ← 14, go to FADE_OUT.
    - Else if !pause and hold_cnt==HOLD_FRAMES-1: target ← img_sel+1 (wrapping), brightness ← 14, go to FADE_OUT.
    - Else if !pause: hold_cnt+1.
    - If pause is high, hold_cnt holds.
  - FADE_OUT, on tick: brightness−1. When brightness==1 at the tick, img_sel ← target, brightness ← 0, go to FADE_IN. Requests arriving during a fade stay pending.
  - FADE_IN, on tick: brightness+1. When brightness==14 at the tick, brightness ← 15, hold_cnt ← 0, go to SHOW.
- pause has no effect on fades or manual requests.
- rom_address ← (DrawX*IMG_W)/640 + ((DrawY*IMG_H)/480)*IMG_W, computed every cycle. Intermediate products use ≥17 bits, and the result is truncated to ADDR_W. When DrawX≥640 or DrawY≥480, rom_address ← 0.
- busy = (state != SHOW), registered alongside the state.

## Timing

- Reset values: state SHOW, img_sel 0, brightness 15, busy 0, rom_address 0, hold_cnt 0, pending cleared, and previous DrawY/next/prev registers 0.
- rom_address latency is 1 vga_clk from DrawX/DrawY. Downstream ROM adds 1 more cycle, and the palette register adds 1.
- A full transition takes 30 frame_ticks: 15 for FADE_OUT (14..0) and 15 for FADE_IN (1..15).
- img_sel changes exactly once per transition, on the tick where brightness becomes 0. It therefore changes only in vertical blank, with no tearing.
- Auto-advance occurs HOLD_FRAMES ticks after entering SHOW, with the pause interval excluded.
- A request edge on the same cycle as a SHOW frame_tick is latched but not consumed until the next tick.
- Reset asserted mid-fade returns to the reset values on the next edge. Pending is discarded.

## Test plan

- Reset then idle, with NUM_IMAGES=3, HOLD_FRAMES=3 and the DrawX/DrawY raster running → img_sel=0, brightness=15 for 3 ticks. Brightness then steps 14..0, img_sel becomes 1 at brightness 0, brightness ramps to 15, busy is high for exactly 30 ticks.
- Address scaling: (DrawX,DrawY)=(0,0)→0, (639,0)→109, (0,479)→10450, (639,479)→10559, (700,100)→0. Each is checked one cycle after stimulus.
- next_req pulse with img_sel=2 and NUM_IMAGES=3 → wraps to img_sel=0. prev_req with img_sel=0 → img_sel=2. Both edges in the same cycle → NEXT taken.
- pause held for 10 ticks in SHOW with HOLD_FRAMES=3 → no transition and hold_cnt frozen. A next_req during the pause still fades to img_sel+1.
- next_req during FADE_IN → the current fade completes, then on the first SHOW tick FADE_OUT starts toward the following image, with no extra wait for HOLD_FRAMES.
- reset asserted at brightness 7 in FADE_OUT → the next cycle shows img_sel=0, brightness=15, busy=0, and the prior pending request is dropped.

Source files
------------

// File: rtl/dog_slideshow_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dog_slideshow_ctrl: frame-synchronous dog-image sequencer with cross-fade
// and scaled sprite ROM addressing.            Revision: 1.0
// ---------------------------------------------------------------------------
module dog_slideshow_ctrl #(
  parameter int NUM_IMAGES  = 10,
  parameter int HOLD_FRAMES = 120,
  parameter int IMG_W       = 110,
  parameter int IMG_H       = 96,
  parameter int ADDR_W      = 14
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pause,
  input  logic              next_req,
  input  logic              prev_req,
  output logic [3:0]        img_sel,
  output logic [ADDR_W-1:0] rom_address,
  output logic [3:0]        brightness,
  output logic              busy
);

  localparam int              HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [3:0]      LAST_IMG  = 4'(NUM_IMAGES - 1);

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        img_sel_q, img_sel_d;
  logic [3:0]        target_q, target_d;
  logic [3:0]        brightness_q, brightness_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_next_q, pend_next_d;
  logic [9:0]        drawy_prev_q;
  logic              next_prev_q, prev_prev_q;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;

  logic       frame_tick;
  logic       next_edge, prev_edge;
  logic [3:0] img_inc, img_dec;
  logic [31:0] x_prod, y_prod;

  always_comb begin
    frame_tick = (DrawY == 10'd480) && (drawy_prev_q != 10'd480);
    next_edge  = next_req & ~next_prev_q;
    prev_edge  = prev_req & ~prev_prev_q;
    img_inc    = (img_sel_q == LAST_IMG) ? 4'd0 : img_sel_q + 4'd1;
    img_dec    = (img_sel_q == 4'd0) ? LAST_IMG : img_sel_q - 4'd1;

    state_d      = state_q;
    img_sel_d    = img_sel_q;
    target_d     = target_q;
    brightness_d = brightness_q;
    hold_cnt_d   = hold_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_next_d  = pend_next_q;

    if (frame_tick) begin
      case (state_q)
        SHOW: begin
          if (pend_valid_q) begin
            target_d     = pend_next_q ? img_inc : img_dec;
            pend_valid_d = 1'b0;
            brightness_d = 4'd14;
            state_d      = FADE_OUT;
          end else if (!pause) begin
            if (hold_cnt_q == HOLD_LAST) begin
              target_d     = img_inc;
              brightness_d = 4'd14;
              state_d      = FADE_OUT;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        FADE_OUT: begin
          // Image swap lands on the black frame, inside vertical blank.
          if (brightness_q == 4'd1) begin
            img_sel_d    = target_q;
            brightness_d = 4'd0;
            state_d      = FADE_IN;
          end else begin
            brightness_d = brightness_q - 4'd1;
          end
        end
        FADE_IN: begin
          if (brightness_q == 4'd14) begin
            brightness_d = 4'd15;
            hold_cnt_d   = '0;
            state_d      = SHOW;
          end else begin
            brightness_d = brightness_q + 4'd1;
          end
        end
        default: state_d = SHOW;
      endcase
    end

    // A fresh edge overrides consumption so a same-tick request is kept.
    if (next_edge) begin
      pend_valid_d = 1'b1;
      pend_next_d  = 1'b1;
    end else if (prev_edge) begin
      pend_valid_d = 1'b1;
      pend_next_d  = 1'b0;
    end

    busy_d = (state_d != SHOW);

    x_prod = {22'd0, DrawX} * 32'(IMG_W);
    y_prod = {22'd0, DrawY} * 32'(IMG_H);
    if ((DrawX >= 10'd640) || (DrawY >= 10'd480)) begin
      rom_address_d = '0;
    end else begin
      rom_address_d = ADDR_W'((x_prod / 32'd640) + (y_prod / 32'd480) * 32'(IMG_W));
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= SHOW;
      img_sel_q     <= 4'd0;
      target_q      <= 4'd0;
      brightness_q  <= 4'd15;
      busy_q        <= 1'b0;
      hold_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_next_q   <= 1'b0;
      drawy_prev_q  <= 10'd0;
      next_prev_q   <= 1'b0;
      prev_prev_q   <= 1'b0;
      rom_address_q <= '0;
    end else begin
      state_q       <= state_d;
      img_sel_q     <= img_sel_d;
      target_q      <= target_d;
      brightness_q  <= brightness_d;
      busy_q        <= busy_d;
      hold_cnt_q    <= hold_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_next_q   <= pend_next_d;
      drawy_prev_q  <= DrawY;
      next_prev_q   <= next_req;
      prev_prev_q   <= prev_req;
      rom_address_q <= rom_address_d;
    end
  end

  assign img_sel     = img_sel_q;
  assign rom_address = rom_address_q;
  assign brightness  = brightness_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
